// File: rtl/axi_nt_response_packetizer.sv
// Turns AXI B and R responses into NoC packets of header, source/ID, data beats and tail flits.
// Flits leave through a single registered stage that holds while the NoC stalls.
module axi_nt_response_packetizer #(
  parameter int FLIT_WIDTH = 34,
  parameter int AXIRDATAWD = 32,
  parameter int AXIIDWD    = 4,
  parameter int SOURCEWD   = 8,
  parameter int NODE_ID    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AXIIDWD-1:0]    BID,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  input  logic [AXIIDWD-1:0]    RID,
  input  logic [AXIRDATAWD-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY,
  output logic [AXIIDWD-1:0]    lookup_id,
  input  logic [SOURCEWD-1:0]   lookup_dest,
  output logic [FLIT_WIDTH-1:0] flit,
  output logic                  valid,
  input  logic                  stall,
  output logic                  resp_done,
  output logic                  resp_done_is_read,
  output logic [AXIIDWD-1:0]    resp_done_id
);

  localparam logic [1:0] FT_HDR  = 2'b01;
  localparam logic [1:0] FT_BODY = 2'b00;
  localparam logic [1:0] FT_TAIL = 2'b10;
  localparam logic [SOURCEWD-1:0] NODE_ADDR = SOURCEWD'(NODE_ID);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, TAIL} state_t;

  state_t                  state_reg;
  logic                    valid_reg;
  logic [FLIT_WIDTH-1:0]   flit_reg;
  logic                    tail_reg;
  logic                    rr_reg;
  logic [1:0]              rresp_acc_reg;
  logic [1:0]              bresp_reg;
  logic [AXIIDWD-1:0]      id_reg;
  logic [SOURCEWD-1:0]     dest_reg;
  logic                    is_read_reg;
  logic [AXIIDWD-1:0]      done_id_reg;
  logic                    done_is_read_reg;

  logic                    adv;
  logic                    sel_b;
  logic                    sel_r;
  logic                    beat;
  logic                    load;
  logic                    load_tail;
  logic [FLIT_WIDTH-1:0]   flit_next;

  function automatic logic [FLIT_WIDTH-1:0] hdr0_flit(input logic [SOURCEWD-1:0] d, input logic rd);
    logic [FLIT_WIDTH-1:0] f;
    f = '0;
    f[FLIT_WIDTH-1 -: 2] = FT_HDR;
    f[FLIT_WIDTH-3]      = rd;
    f[SOURCEWD-1:0]      = d;
    return f;
  endfunction

  // The output register may take a new flit when it is empty or its flit leaves this cycle.
  assign adv    = !valid_reg || !stall;
  // With both responses pending, rr_reg=0 favours R.
  assign sel_b  = BVALID && (!RVALID || rr_reg);
  assign sel_r  = RVALID && (!BVALID || !rr_reg);
  assign BREADY = (state_reg == IDLE) && sel_b;
  assign RREADY = (state_reg == DATA) && adv;
  assign beat   = RVALID && RREADY;
  assign lookup_id = (state_reg == IDLE) ? (sel_r ? RID : BID) : id_reg;

  assign flit              = flit_reg;
  assign valid             = valid_reg;
  assign resp_done         = valid_reg && !stall && tail_reg;
  assign resp_done_id      = done_id_reg;
  assign resp_done_is_read = done_is_read_reg;

  always_comb begin
    load      = 1'b0;
    load_tail = 1'b0;
    flit_next = '0;
    case (state_reg)
      // Header goes straight out of IDLE when the register is free; HDR0 covers the stalled case.
      IDLE: if (sel_b || sel_r) begin
        load      = 1'b1;
        flit_next = hdr0_flit(lookup_dest, sel_r);
      end
      HDR0: begin
        load      = 1'b1;
        flit_next = hdr0_flit(dest_reg, is_read_reg);
      end
      HDR1: begin
        load = 1'b1;
        flit_next[FLIT_WIDTH-1 -: 2]              = FT_BODY;
        flit_next[SOURCEWD-1:0]                   = NODE_ADDR;
        flit_next[SOURCEWD+AXIIDWD-1:SOURCEWD]    = id_reg;
      end
      DATA: if (beat) begin
        load = 1'b1;
        flit_next[FLIT_WIDTH-1 -: 2]  = FT_BODY;
        flit_next[AXIRDATAWD-1:0]     = RDATA;
      end
      TAIL: begin
        load      = 1'b1;
        load_tail = 1'b1;
        flit_next[FLIT_WIDTH-1 -: 2] = FT_TAIL;
        flit_next[1:0]               = is_read_reg ? rresp_acc_reg : bresp_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      valid_reg        <= 1'b0;
      flit_reg         <= '0;
      tail_reg         <= 1'b0;
      rr_reg           <= 1'b0;
      rresp_acc_reg    <= 2'b00;
      bresp_reg        <= 2'b00;
      id_reg           <= '0;
      dest_reg         <= '0;
      is_read_reg      <= 1'b0;
      done_id_reg      <= '0;
      done_is_read_reg <= 1'b0;
    end else begin
      if (adv) begin
        valid_reg <= load;
        tail_reg  <= load_tail;
        if (load) flit_reg <= flit_next;
      end
      case (state_reg)
        IDLE: begin
          if (BVALID && RVALID) rr_reg <= !rr_reg;
          if (sel_b) begin
            id_reg      <= BID;
            bresp_reg   <= BRESP;
            is_read_reg <= 1'b0;
            dest_reg    <= lookup_dest;
            state_reg   <= adv ? HDR1 : HDR0;
          end else if (sel_r) begin
            id_reg        <= RID;
            is_read_reg   <= 1'b1;
            dest_reg      <= lookup_dest;
            rresp_acc_reg <= 2'b00;
            state_reg     <= adv ? HDR1 : HDR0;
          end
        end
        HDR0: if (adv) state_reg <= HDR1;
        HDR1: if (adv) state_reg <= is_read_reg ? DATA : TAIL;
        DATA: if (beat) begin
          if (RRESP > rresp_acc_reg) rresp_acc_reg <= RRESP;
          if (RLAST) state_reg <= TAIL;
        end
        TAIL: if (adv) begin
          // Completion info is captured here since IDLE may relatch id_reg while the tail is stalled.
          done_id_reg      <= id_reg;
          done_is_read_reg <= is_read_reg;
          state_reg        <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_nt_response_packetizer.sv
// Scoreboard bench: drivers push expected packets, a negedge monitor checks every transferred flit.
`timescale 1ns/1ps
module tb_axi_nt_response_packetizer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  BID = '0;
  logic [1:0]  BRESP = '0;
  logic        BVALID = 1'b0;
  logic        BREADY;
  logic [3:0]  RID = '0;
  logic [31:0] RDATA = '0;
  logic [1:0]  RRESP = '0;
  logic        RLAST = 1'b0;
  logic        RVALID = 1'b0;
  logic        RREADY;
  logic [3:0]  lookup_id;
  logic [7:0]  lookup_dest;
  logic [33:0] flit;
  logic        valid;
  logic        stall;
  logic        resp_done;
  logic        resp_done_is_read;
  logic [3:0]  resp_done_id;

  logic [7:0]  dest_tbl [16];
  logic [31:0] beat_data [8];
  logic [1:0]  beat_resp [8];
  logic [33:0] exp_flit [$];
  logic [4:0]  exp_done [$];

  int n_checks = 0;
  int n_pass = 0;
  int hs_count = 0;
  int aborted_done = 0;
  bit mon_en = 1'b1;
  bit stall_mode = 1'b0;
  bit force_stall = 1'b0;

  assign lookup_dest = dest_tbl[lookup_id];

  axi_nt_response_packetizer dut (
    .clk(clk), .rst(rst),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .lookup_id(lookup_id), .lookup_dest(lookup_dest),
    .flit(flit), .valid(valid), .stall(stall),
    .resp_done(resp_done), .resp_done_is_read(resp_done_is_read), .resp_done_id(resp_done_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference packet formats for the default parameters (NODE_ID=0, SOURCEWD=8, AXIIDWD=4).
  function automatic logic [33:0] m_hdr(input logic [7:0] d, input bit rd);
    return {2'b01, rd, 23'd0, d};
  endfunction
  function automatic logic [33:0] m_hdr1(input logic [3:0] id);
    return {2'b00, 20'd0, id, 8'd0};
  endfunction
  function automatic logic [33:0] m_data(input logic [31:0] d);
    return {2'b00, d};
  endfunction
  function automatic logic [33:0] m_tail(input logic [1:0] r);
    return {2'b10, 30'd0, r};
  endfunction

  task automatic push_write(input logic [3:0] id, input logic [1:0] resp);
    exp_flit.push_back(m_hdr(dest_tbl[id], 1'b0));
    exp_flit.push_back(m_hdr1(id));
    exp_flit.push_back(m_tail(resp));
    exp_done.push_back({1'b0, id});
  endtask

  task automatic push_read(input logic [3:0] id, input int n);
    logic [1:0] worst;
    worst = 2'd0;
    exp_flit.push_back(m_hdr(dest_tbl[id], 1'b1));
    exp_flit.push_back(m_hdr1(id));
    for (int i = 0; i < n; i++) begin
      exp_flit.push_back(m_data(beat_data[i]));
      if (beat_resp[i] > worst) worst = beat_resp[i];
    end
    exp_flit.push_back(m_tail(worst));
    exp_done.push_back({1'b1, id});
  endtask

  task automatic wait_ready(input bit is_r);
    int cyc;
    bit seen;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      seen = is_r ? RREADY : BREADY;
    end
    if (!seen) chk(1'b0, is_r ? "rready_timeout" : "bready_timeout", 64'(cyc), 64'd2000);
    @(posedge clk);
    #1;
  endtask

  task automatic send_write(input logic [3:0] id, input logic [1:0] resp);
    BID = id;
    BRESP = resp;
    BVALID = 1'b1;
    wait_ready(1'b0);
    BVALID = 1'b0;
  endtask

  task automatic send_read(input logic [3:0] id, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      RID = id;
      RDATA = beat_data[i];
      RRESP = beat_resp[i];
      RLAST = (i == n - 1);
      RVALID = 1'b1;
      wait_ready(1'b1);
      RVALID = 1'b0;
      RLAST = 1'b0;
      if (gaps) begin
        int k;
        k = $urandom_range(0, 2);
        repeat (k) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic rand_beats(input int n);
    for (int i = 0; i < n; i++) begin
      beat_data[i] = $urandom;
      beat_resp[i] = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((exp_flit.size() != 0 || exp_done.size() != 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_flit.size() != 0 || exp_done.size() != 0)
      chk(1'b0, "drain_timeout", 64'(exp_flit.size()), 64'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Stall source: random in soak mode, otherwise follows force_stall.
  initial begin
    stall = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      stall = stall_mode ? ($urandom_range(0, 3) == 0) : force_stall;
    end
  end

  // Monitor: a flit transfers at the next edge when valid && !stall at the negedge.
  initial begin
    bit hold_pending;
    logic [33:0] held;
    logic [33:0] e;
    logic [4:0] ed;
    bit is_tail;
    hold_pending = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending)
          chk(valid && flit == held, "stall_hold", {29'd0, valid, flit}, {29'd0, 1'b1, held});
        hold_pending = valid && stall;
        held = flit;
        if (RVALID && RREADY) hs_count++;
        if (!mon_en) begin
          if (resp_done) aborted_done++;
        end else if (valid && !stall) begin
          if (exp_flit.size() == 0) begin
            chk(1'b0, "unexpected_flit", 64'(flit), 64'd0);
          end else begin
            e = exp_flit.pop_front();
            chk(flit === e, "flit", 64'(flit), 64'(e));
            is_tail = (e[33:32] == 2'b10);
            chk(resp_done == is_tail, "resp_done", 64'(resp_done), 64'(is_tail));
            if (is_tail) begin
              if (exp_done.size() == 0) begin
                chk(1'b0, "unexpected_done", 64'({resp_done_is_read, resp_done_id}), 64'd0);
              end else begin
                ed = exp_done.pop_front();
                chk({resp_done_is_read, resp_done_id} == ed, "done_info",
                    64'({resp_done_is_read, resp_done_id}), 64'(ed));
              end
            end
          end
        end else if (resp_done) begin
          chk(1'b0, "spurious_resp_done", 64'd1, 64'd0);
        end
      end
    end
  end

  initial begin
    int hs0;
    int cyc;
    bit seen;
    for (int i = 0; i < 16; i++) dest_tbl[i] = 8'($urandom);
    dest_tbl[5] = 8'h12;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk(valid == 1'b0, "rst_valid", 64'(valid), 64'd0);
    chk(flit == 34'd0, "rst_flit", 64'(flit), 64'd0);
    chk(BREADY == 1'b0 && RREADY == 1'b0, "rst_ready", 64'({BREADY, RREADY}), 64'd0);
    chk(resp_done == 1'b0, "rst_done", 64'(resp_done), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Directed write with literal expectations
    exp_flit.push_back(34'h1_00000012);
    exp_flit.push_back(34'h0_00000500);
    exp_flit.push_back(34'h2_00000002);
    exp_done.push_back({1'b0, 4'd5});
    send_write(4'd5, 2'd2);
    drain();

    // Directed 4-beat read
    for (int i = 0; i < 4; i++) begin
      beat_data[i] = 32'hA0 + 32'(i);
      beat_resp[i] = (i == 2) ? 2'd2 : 2'd0;
    end
    hs0 = hs_count;
    push_read(4'd3, 4);
    send_read(4'd3, 4, 1'b0);
    drain();
    chk(hs_count - hs0 == 4, "read_handshakes", 64'(hs_count - hs0), 64'd4);

    // Simultaneous B and R: first tie after reset favours R, the next favours B
    rand_beats(2);
    push_read(4'd9, 2);
    push_write(4'd4, 2'd1);
    fork
      send_read(4'd9, 2, 1'b0);
      send_write(4'd4, 2'd1);
    join
    drain();
    rand_beats(3);
    push_write(4'd6, 2'd3);
    push_read(4'd10, 3);
    fork
      send_read(4'd10, 3, 1'b0);
      send_write(4'd6, 2'd3);
    join
    drain();

    // Five stalled cycles in the middle of a read
    rand_beats(6);
    push_read(4'd2, 6);
    fork
      send_read(4'd2, 6, 1'b0);
      begin
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 2000) begin
          @(negedge clk);
          cyc++;
          seen = RREADY;
        end
        if (!seen) chk(1'b0, "stall_setup_timeout", 64'(cyc), 64'd2000);
        force_stall = 1'b1;
        @(posedge clk);
        repeat (5) begin
          @(negedge clk);
          chk(RREADY == 1'b0, "rready_during_stall", 64'(RREADY), 64'd0);
          chk(valid == 1'b1, "valid_during_stall", 64'(valid), 64'd1);
        end
        force_stall = 1'b0;
      end
    join
    drain();

    // Randomized soak with random backpressure and beat gaps
    stall_mode = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        logic [3:0] id;
        logic [1:0] rs;
        id = 4'($urandom);
        rs = 2'($urandom);
        push_write(id, rs);
        send_write(id, rs);
      end else begin
        logic [3:0] id;
        int n;
        id = 4'($urandom);
        n = $urandom_range(1, 5);
        rand_beats(n);
        push_read(id, n);
        send_read(id, n, 1'b1);
      end
    end
    drain();
    stall_mode = 1'b0;

    // Asynchronous reset during read beat 2; the packet is dropped
    mon_en = 1'b0;
    RID = 4'd7;
    for (int i = 0; i < 2; i++) begin
      RDATA = 32'hB0 + 32'(i);
      RRESP = 2'd0;
      RLAST = 1'b0;
      RVALID = 1'b1;
      wait_ready(1'b1);
    end
    RDATA = 32'hB2;
    @(negedge clk);
    #2;
    chk(valid == 1'b1, "pre_reset_valid", 64'(valid), 64'd1);
    rst = 1'b0;
    #1;
    chk(valid == 1'b0, "async_rst_valid", 64'(valid), 64'd0);
    chk(flit == 34'd0, "async_rst_flit", 64'(flit), 64'd0);
    chk(RREADY == 1'b0 && BREADY == 1'b0, "async_rst_ready", 64'({BREADY, RREADY}), 64'd0);
    chk(resp_done == 1'b0, "async_rst_done", 64'(resp_done), 64'd0);
    RVALID = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;
    push_write(4'd8, 2'd1);
    send_write(4'd8, 2'd1);
    drain();

    // Tie priority returns to R after reset
    rand_beats(1);
    push_read(4'd11, 1);
    push_write(4'd12, 2'd0);
    fork
      send_read(4'd11, 1, 1'b0);
      send_write(4'd12, 2'd0);
    join
    drain();

    chk(aborted_done == 0, "aborted_resp_done", 64'(aborted_done), 64'd0);
    chk(exp_flit.size() == 0, "leftover_flits", 64'(exp_flit.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
